// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multicycle controller: ISA codes, datapath select
// encodings, FSM states and trap causes.
package multicycle_control_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned WAIT_W  = 8;
    localparam int unsigned CODE_W  = 5;

    // {isa_op, funct}; JAL and BEQ are matched with funct forced to zero
    typedef enum logic [CODE_W-1:0] {
        ISA_ADD  = 5'b00_000,
        ISA_SUB  = 5'b00_001,
        ISA_AND  = 5'b00_011,
        ISA_OR   = 5'b00_100,
        ISA_SLT  = 5'b00_101,
        ISA_ADDI = 5'b01_000,
        ISA_LUI  = 5'b01_001,
        ISA_LOAD = 5'b01_010,
        ISA_STOR = 5'b01_011,
        ISA_JAL  = 5'b10_000,
        ISA_BEQ  = 5'b11_000
    } isa_t;

    typedef enum logic [2:0] {
        ALU_NOP = 3'd0,
        ALU_ADD = 3'd1,
        ALU_SUB = 3'd2,
        ALU_AND = 3'd3,
        ALU_OR  = 3'd4,
        ALU_GT  = 3'd5,
        ALU_ET  = 3'd6
    } alu_func_t;

    typedef enum logic [1:0] {
        DATA_NOP  = 2'd0,
        DATA_ALU  = 2'd1,
        DATA_WORD = 2'd2,
        DATA_PC   = 2'd3
    } data_s_t;

    typedef enum logic [0:0] {
        PC_INC = 1'b0,
        PC_ADD = 1'b1
    } pc_s_t;

    typedef enum logic [1:0] {
        OPERAND_NOP     = 2'd0,
        OPERAND_RY      = 2'd1,
        OPERAND_KK      = 2'd2,
        OPERAND_SHIFTED = 2'd3
    } operand_s_t;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        TRAP_NONE    = 2'd0,
        TRAP_ILLEGAL = 2'd1,
        TRAP_TIMEOUT = 2'd2
    } trap_cause_t;

    // Normalise {isa_op, funct}: the jump and branch classes carry no funct
    function automatic isa_t isa_of(input logic [CODE_W-1:0] code);
        if (code[4]) begin
            return isa_t'({code[4:3], 3'b000});
        end
        return isa_t'(code);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Memory / datapath control bus between the multicycle controller and its datapath.
interface multicycle_control_if;
    import multicycle_control_pkg::*;

    logic [INSTR_W-1:0] instr;
    logic               mem_ready;
    logic               alu_flag;
    logic               mem_req;
    logic               mem_we;
    logic               addr_sel;
    logic               ir_load;
    logic               pc_write;
    pc_s_t              pc_sel;
    operand_s_t         operand_sel;
    alu_func_t          alu_func;
    data_s_t            data_sel;
    logic               reg_write;
    logic               retire;
    logic               trap;
    logic [1:0]         trap_cause;

    modport master (
        input  instr, mem_ready, alu_flag,
        output mem_req, mem_we, addr_sel, ir_load, pc_write, pc_sel,
               operand_sel, alu_func, data_sel, reg_write, retire, trap, trap_cause
    );

    modport slave (
        output instr, mem_ready, alu_flag,
        input  mem_req, mem_we, addr_sel, ir_load, pc_write, pc_sel,
               operand_sel, alu_func, data_sel, reg_write, retire, trap, trap_cause
    );

endinterface

// File: rtl/multicycle_control_isa_decode.sv
// Combinational instruction decoder: IR opcode field -> ALU operand/function and legality.
module isa_decode
    import multicycle_control_pkg::*;
(
    input  logic [CODE_W-1:0] ir_code,
    output operand_s_t        operand_sel,
    output alu_func_t         alu_func,
    output logic              legal
);

    always_comb begin
        operand_sel = OPERAND_NOP;
        alu_func    = ALU_NOP;
        legal       = 1'b1;
        case (isa_of(ir_code))
            ISA_ADD:  begin operand_sel = OPERAND_RY; alu_func = ALU_ADD; end
            ISA_SUB:  begin operand_sel = OPERAND_RY; alu_func = ALU_SUB; end
            ISA_AND:  begin operand_sel = OPERAND_RY; alu_func = ALU_AND; end
            ISA_OR:   begin operand_sel = OPERAND_RY; alu_func = ALU_OR;  end
            ISA_SLT:  begin operand_sel = OPERAND_RY; alu_func = ALU_GT;  end
            ISA_ADDI,
            ISA_LOAD,
            ISA_STOR: begin operand_sel = OPERAND_KK; alu_func = ALU_ADD; end
            // LUI passes the shifted immediate straight through the ALU
            ISA_LUI:  operand_sel = OPERAND_SHIFTED;
            ISA_BEQ:  begin operand_sel = OPERAND_RY; alu_func = ALU_ET;  end
            ISA_JAL:  ;
            default:  legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: fetch/decode/execute/memory/writeback sequencing
// with a memory wait-timeout and an absorbing trap state.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
)
(
    input  logic                 clk,
    input  logic                 reset_n,
    multicycle_control_if.master bus
);

    state_t             state;
    state_t             state_next;
    trap_cause_t        cause_q;
    trap_cause_t        cause_next;
    logic [INSTR_W-1:0] ir;
    logic [WAIT_W-1:0]  wait_cnt;

    isa_t       cur_isa;
    operand_s_t dec_operand;
    alu_func_t  dec_alu;
    logic       dec_legal;
    logic       wait_expire;
    logic       unused_ir_operands;

    logic       mem_req_c;
    logic       mem_we_c;
    logic       addr_sel_c;
    logic       ir_load_c;
    logic       pc_write_c;
    pc_s_t      pc_sel_c;
    operand_s_t operand_sel_c;
    alu_func_t  alu_func_c;
    data_s_t    data_sel_c;
    logic       reg_write_c;
    logic       retire_c;
    logic       trap_c;

    isa_decode u_isa_decode (
        .ir_code     (ir[15:11]),
        .operand_sel (dec_operand),
        .alu_func    (dec_alu),
        .legal       (dec_legal)
    );

    assign cur_isa            = isa_of(ir[15:11]);
    assign unused_ir_operands = ^ir[10:0];

    // True when one more unanswered request cycle would reach the limit
    assign wait_expire = (({1'b0, wait_cnt} + 9'd1) == 9'(MEM_TIMEOUT));

    // State, IR, trap cause and wait counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_FETCH;
            cause_q  <= TRAP_NONE;
            ir       <= '0;
            wait_cnt <= '0;
        end else begin
            state   <= state_next;
            cause_q <= cause_next;
            if (ir_load_c) begin
                ir <= bus.instr;
            end
            // Idle and completed cycles clear it, so every FETCH/MEMORY entry starts at zero
            if (mem_req_c && !bus.mem_ready) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // Next state and Moore/mem_ready-qualified control outputs
    always_comb begin
        state_next    = state;
        cause_next    = cause_q;
        mem_req_c     = 1'b0;
        mem_we_c      = 1'b0;
        addr_sel_c    = 1'b0;
        ir_load_c     = 1'b0;
        pc_write_c    = 1'b0;
        pc_sel_c      = PC_INC;
        operand_sel_c = OPERAND_NOP;
        alu_func_c    = ALU_NOP;
        data_sel_c    = DATA_NOP;
        reg_write_c   = 1'b0;
        retire_c      = 1'b0;
        trap_c        = 1'b0;

        // Reset forces idle outputs immediately, without waiting for a clock edge
        if (reset_n) begin
            case (state)
                ST_FETCH: begin
                    mem_req_c = 1'b1;
                    if (bus.mem_ready) begin
                        ir_load_c  = 1'b1;
                        state_next = ST_DECODE;
                    end else if (wait_expire) begin
                        state_next = ST_TRAP;
                        cause_next = TRAP_TIMEOUT;
                    end
                end

                ST_DECODE: begin
                    if (dec_legal) begin
                        state_next = ST_EXECUTE;
                    end else begin
                        state_next = ST_TRAP;
                        cause_next = TRAP_ILLEGAL;
                    end
                end

                ST_EXECUTE: begin
                    operand_sel_c = dec_operand;
                    alu_func_c    = dec_alu;
                    case (cur_isa)
                        ISA_LOAD,
                        ISA_STOR: state_next = ST_MEMORY;
                        ISA_BEQ: begin
                            pc_write_c = 1'b1;
                            retire_c   = 1'b1;
                            pc_sel_c   = bus.alu_flag ? PC_ADD : PC_INC;
                            state_next = ST_FETCH;
                        end
                        default:  state_next = ST_WRITEBACK;
                    endcase
                end

                ST_MEMORY: begin
                    mem_req_c     = 1'b1;
                    addr_sel_c    = 1'b1;
                    mem_we_c      = (cur_isa == ISA_STOR);
                    operand_sel_c = dec_operand;
                    alu_func_c    = dec_alu;
                    if (bus.mem_ready) begin
                        if (cur_isa == ISA_LOAD) begin
                            reg_write_c = 1'b1;
                            data_sel_c  = DATA_WORD;
                        end
                        pc_write_c = 1'b1;
                        retire_c   = 1'b1;
                        state_next = ST_FETCH;
                    end else if (wait_expire) begin
                        state_next = ST_TRAP;
                        cause_next = TRAP_TIMEOUT;
                    end
                end

                ST_WRITEBACK: begin
                    reg_write_c = 1'b1;
                    pc_write_c  = 1'b1;
                    retire_c    = 1'b1;
                    state_next  = ST_FETCH;
                    if (cur_isa == ISA_JAL) begin
                        data_sel_c = DATA_PC;
                        pc_sel_c   = PC_ADD;
                    end else begin
                        data_sel_c = DATA_ALU;
                    end
                end

                ST_TRAP: begin
                    trap_c = 1'b1;
                end

                default: begin
                    state_next = ST_TRAP;
                end
            endcase
        end
    end

    assign bus.mem_req     = mem_req_c;
    assign bus.mem_we      = mem_we_c;
    assign bus.addr_sel    = addr_sel_c;
    assign bus.ir_load     = ir_load_c;
    assign bus.pc_write    = pc_write_c;
    assign bus.pc_sel      = pc_sel_c;
    assign bus.operand_sel = operand_sel_c;
    assign bus.alu_func    = alu_func_c;
    assign bus.data_sel    = data_sel_c;
    assign bus.reg_write   = reg_write_c;
    assign bus.retire      = retire_c;
    assign bus.trap        = trap_c;
    assign bus.trap_cause  = cause_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised bench for multicycle_control: an instruction-level model expands each
// instruction into its expected per-cycle trace, which is replayed and compared.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    localparam int unsigned T        = 4;
    localparam int unsigned N_RANDOM = 150;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       ir_load;
        logic       pc_write;
        pc_s_t      pc_sel;
        operand_s_t operand_sel;
        alu_func_t  alu_func;
        data_s_t    data_sel;
        logic       reg_write;
        logic       retire;
        logic       trap;
        logic [1:0] trap_cause;
    } obs_t;

    typedef struct {
        logic        rst_n;
        logic [15:0] instr;
        logic        mem_ready;
        logic        alu_flag;
        int          inum;
        obs_t        e;
    } cyc_t;

    logic clk = 1'b0;
    logic reset_n;

    multicycle_control_if bus();

    multicycle_control #(.MEM_TIMEOUT(T)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    cyc_t tr[$];
    int   errors      = 0;
    int   checks      = 0;
    int   retire_exp  = 0;
    int   retire_seen = 0;

    function automatic obs_t idle_obs();
        obs_t o;
        o             = '0;
        o.pc_sel      = PC_INC;
        o.operand_sel = OPERAND_NOP;
        o.alu_func    = ALU_NOP;
        o.data_sel    = DATA_NOP;
        return o;
    endfunction

    function automatic logic [15:0] rnd16();
        return 16'($urandom);
    endfunction

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    function automatic int pick_wait();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 12) return 0;
        if (r < 16) return int'($urandom_range(1, 2));
        if (r < 18) return 3;
        return int'($urandom_range(4, 6));
    endfunction

    // Instruction table: returns legality and the EXECUTE-phase ALU controls
    function automatic bit exec_ctl(input logic [15:0] w, output operand_s_t o, output alu_func_t a);
        o = OPERAND_NOP;
        a = ALU_NOP;
        case (w[15:14])
            2'd0: case (w[13:11])
                3'd0: begin o = OPERAND_RY; a = ALU_ADD; end
                3'd1: begin o = OPERAND_RY; a = ALU_SUB; end
                3'd3: begin o = OPERAND_RY; a = ALU_AND; end
                3'd4: begin o = OPERAND_RY; a = ALU_OR;  end
                3'd5: begin o = OPERAND_RY; a = ALU_GT;  end
                default: return 1'b0;
            endcase
            2'd1: case (w[13:11])
                3'd0, 3'd2, 3'd3: begin o = OPERAND_KK; a = ALU_ADD; end
                3'd1: o = OPERAND_SHIFTED;
                default: return 1'b0;
            endcase
            2'd2: ;
            default: begin o = OPERAND_RY; a = ALU_ET; end
        endcase
        return 1'b1;
    endfunction

    task automatic push(input logic rst_n, input logic [15:0] instr, input logic rdy,
                        input logic flag, input int id, input obs_t e);
        cyc_t c;
        c.rst_n     = rst_n;
        c.instr     = instr;
        c.mem_ready = rdy;
        c.alu_flag  = flag;
        c.inum      = id;
        c.e         = e;
        tr.push_back(c);
    endtask

    task automatic add_reset(input logic rdy);
        push(1'b0, rnd16(), rdy, rbit(), -1, idle_obs());
    endtask

    task automatic add_trap_tail(input logic [1:0] cause);
        obs_t e;
        e            = idle_obs();
        e.trap       = 1'b1;
        e.trap_cause = cause;
        for (int i = 0; i < 3; i++) push(1'b1, rnd16(), rbit(), rbit(), -1, e);
        add_reset(rbit());
    endtask

    // Expand one instruction into expected cycles; cause != 0 means it trapped
    task automatic add_instr(input logic [15:0] w, input int fw, input int mw,
                             input int flag_sel, input int id, output logic [1:0] cause);
        obs_t       e;
        operand_s_t o;
        alu_func_t  a;
        logic       fl;
        bit         is_load;
        bit         is_stor;
        cause   = 2'd0;
        is_load = (w[15:11] == 5'b01010);
        is_stor = (w[15:11] == 5'b01011);
        for (int k = 0; k <= fw; k++) begin
            e         = idle_obs();
            e.mem_req = 1'b1;
            if (k == fw) begin
                e.ir_load = 1'b1;
                push(1'b1, w, 1'b1, rbit(), id, e);
            end else begin
                push(1'b1, rnd16(), 1'b0, rbit(), id, e);
                if (k + 1 == int'(T)) begin cause = 2'd2; return; end
            end
        end
        push(1'b1, rnd16(), rbit(), rbit(), id, idle_obs());
        if (!exec_ctl(w, o, a)) begin cause = 2'd1; return; end
        e             = idle_obs();
        e.operand_sel = o;
        e.alu_func    = a;
        if (w[15:14] == 2'd3) begin
            fl         = (flag_sel < 0) ? rbit() : 1'(flag_sel);
            e.pc_write = 1'b1;
            e.retire   = 1'b1;
            e.pc_sel   = fl ? PC_ADD : PC_INC;
            push(1'b1, rnd16(), rbit(), fl, id, e);
            retire_exp++;
            return;
        end
        push(1'b1, rnd16(), rbit(), rbit(), id, e);
        if (is_load || is_stor) begin
            for (int k = 0; k <= mw; k++) begin
                e             = idle_obs();
                e.mem_req     = 1'b1;
                e.addr_sel    = 1'b1;
                e.mem_we      = is_stor;
                e.operand_sel = o;
                e.alu_func    = a;
                if (k == mw) begin
                    if (is_load) begin
                        e.reg_write = 1'b1;
                        e.data_sel  = DATA_WORD;
                    end
                    e.pc_write = 1'b1;
                    e.retire   = 1'b1;
                    push(1'b1, rnd16(), 1'b1, rbit(), id, e);
                    retire_exp++;
                end else begin
                    push(1'b1, rnd16(), 1'b0, rbit(), id, e);
                    if (k + 1 == int'(T)) begin cause = 2'd2; return; end
                end
            end
        end else begin
            e           = idle_obs();
            e.reg_write = 1'b1;
            e.pc_write  = 1'b1;
            e.retire    = 1'b1;
            e.data_sel  = (w[15:14] == 2'd2) ? DATA_PC : DATA_ALU;
            e.pc_sel    = (w[15:14] == 2'd2) ? PC_ADD : PC_INC;
            push(1'b1, rnd16(), rbit(), rbit(), id, e);
            retire_exp++;
        end
    endtask

    task automatic pin(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL model %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic check_obs(input int n, input cyc_t c);
        obs_t got;
        got.mem_req     = bus.mem_req;
        got.mem_we      = bus.mem_we;
        got.addr_sel    = bus.addr_sel;
        got.ir_load     = bus.ir_load;
        got.pc_write    = bus.pc_write;
        got.pc_sel      = bus.pc_sel;
        got.operand_sel = bus.operand_sel;
        got.alu_func    = bus.alu_func;
        got.data_sel    = bus.data_sel;
        got.reg_write   = bus.reg_write;
        got.retire      = bus.retire;
        got.trap        = bus.trap;
        got.trap_cause  = bus.trap_cause;
        checks++;
        if (got !== c.e) begin
            errors++;
            $display("FAIL outputs cycle=%0d instr#%0d rst_n=%b rdy=%b: got=%h expected=%h",
                     n, c.inum, c.rst_n, c.mem_ready, got, c.e);
        end
        if (got.retire === 1'b1) retire_seen++;
    endtask

    initial begin
        int          s;
        int          cnt;
        logic [1:0]  cause;
        logic [15:0] w;

        reset_n       = 1'b0;
        bus.instr     = '0;
        bus.mem_ready = 1'b0;
        bus.alu_flag  = 1'b0;

        add_reset(1'b0);
        add_reset(1'b1);

        // ADD with zero-wait memory
        s = tr.size();
        add_instr(16'h0000, 0, 0, -1, 1, cause);
        pin("add_len", tr.size() - s, 4);
        pin("add_ir_load_c1", int'(tr[s].e.ir_load), 1);
        pin("add_alu_exec", int'(tr[s+2].e.alu_func), int'(ALU_ADD));
        pin("add_wb_c4", int'(tr[s+3].e.reg_write & tr[s+3].e.retire), 1);

        // BEQ taken / not taken
        s = tr.size();
        add_instr(16'hC000, 0, 0, 1, 2, cause);
        pin("beq_len", tr.size() - s, 3);
        pin("beq_taken_pcsel", int'(tr[s+2].e.pc_sel), int'(PC_ADD));
        pin("beq_no_regwrite", int'(tr[s+2].e.reg_write), 0);
        s = tr.size();
        add_instr(16'hC000, 0, 0, 0, 3, cause);
        pin("beq_not_taken_pcsel", int'(tr[s+2].e.pc_sel), int'(PC_INC));

        // STOR with three wait cycles in MEMORY
        s = tr.size();
        add_instr(16'h5800, 0, 3, -1, 4, cause);
        pin("stor_len", tr.size() - s, 7);
        cnt = 0;
        for (int i = 3; i < 7; i++) cnt += int'(tr[s+i].e.mem_we) + int'(tr[s+i].e.reg_write);
        pin("stor_we_cycles", cnt, 4);
        pin("stor_retire_last", int'(tr[s+6].e.retire), 1);

        // Fetch timeout, and mem_ready arriving on the limit cycle
        s = tr.size();
        add_instr(16'h0000, 10, 0, -1, 5, cause);
        pin("timeout_len", tr.size() - s, 4);
        pin("timeout_cause", int'(cause), 2);
        add_trap_tail(cause);
        s = tr.size();
        add_instr(16'h0000, 3, 0, -1, 6, cause);
        pin("late_ready_cause", int'(cause), 0);
        pin("late_ready_ir_load", int'(tr[s+3].e.ir_load), 1);

        // Undefined RR funct
        s = tr.size();
        add_instr(16'h1000, 0, 0, -1, 7, cause);
        pin("illegal_len", tr.size() - s, 2);
        pin("illegal_cause", int'(cause), 1);
        add_trap_tail(cause);

        // Reset during LOAD's MEMORY phase, with mem_ready high as reset hits
        add_instr(16'h5000, 0, 2, -1, 8, cause);
        void'(tr.pop_back());
        retire_exp--;
        add_reset(1'b1);
        add_instr(16'h0000, 0, 0, -1, 9, cause);

        for (int i = 0; i < int'(N_RANDOM); i++) begin
            w = rnd16();
            add_instr(w, pick_wait(), pick_wait(), -1, 100 + i, cause);
            if (cause != 2'd0) add_trap_tail(cause);
        end

        foreach (tr[n]) begin
            @(negedge clk);
            reset_n       = tr[n].rst_n;
            bus.instr     = tr[n].instr;
            bus.mem_ready = tr[n].mem_ready;
            bus.alu_flag  = tr[n].alu_flag;
            #2;
            check_obs(n, tr[n]);
        end

        checks++;
        if (retire_seen != retire_exp) begin
            errors++;
            $display("FAIL retire_count: got=%0d expected=%0d", retire_seen, retire_exp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: cycles the block waits for mem_ready before it traps; legal range 1..255.
REQ-002 clk  in  1  sole clock; every register updates on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 instr  in  16  instruction bus from memory; isa_op = instr[15:14], funct = instr[13:11]; sampled only while ir_load=1.
REQ-005 mem_ready  in  1  memory completion for the current request; ignored while mem_req=0.
REQ-006 alu_flag  in  1  ALU compare result (ALU_ET) for BEQ.
REQ-007 mem_req  out  1  memory request, held high until the cycle in which mem_ready=1.
REQ-008 mem_we  out  1  write strobe, qualified by mem_req; high only for STOR.
REQ-009 addr_sel  out  1  0 = PC address (fetch), 1 = ALU address (data).
REQ-010 ir_load  out  1  latch instr into the internal IR.
REQ-011 pc_write  out  1  PC update strobe; pc_sel  out  pc_s_t  PC source.
REQ-012 operand_sel  out  operand_s_t; alu_func  out  alu_func_t; data_sel  out  data_s_t; reg_write  out  1.
REQ-013 retire  out  1  one-cycle pulse per completed instruction; trap  out  1; trap_cause  out  2  (0 none, 1 illegal, 2 timeout).

Function
REQ-014 The FSM SHALL have the states FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and TRAP; outputs are Moore-style per state and decoded IR, plus mem_ready qualification.
REQ-015 Idle values in every state unless overridden: strobes 0, pc_sel=PC_INC, operand_sel=OPERAND_NOP, alu_func=ALU_NOP, data_sel=DATA_NOP.
REQ-016 FETCH: mem_req=1, addr_sel=0, mem_we=0; when mem_ready=1: ir_load=1 and next state DECODE; otherwise stay in FETCH.
REQ-017 DECODE: {isa_op,funct} matching a defined isa_t code (JAL/BEQ ignore funct) -> EXECUTE; otherwise -> TRAP with trap_cause=1.
REQ-018 EXECUTE decode: RR -> OPERAND_RY with ADD/SUB/AND/OR/SLT -> ALU_ADD/SUB/AND/OR/GT; ADDI/LOAD/STOR -> OPERAND_KK, ALU_ADD; LUI -> OPERAND_SHIFTED, ALU_NOP (pass-through); BEQ -> OPERAND_RY, ALU_ET.
REQ-019 EXECUTE next state: RR/ADDI/LUI/JAL -> WRITEBACK; LOAD/STOR -> MEMORY; BEQ -> FETCH with pc_write=1, retire=1, pc_sel=PC_ADD if alu_flag=1, else PC_INC.
REQ-020 MEMORY: mem_req=1, addr_sel=1, mem_we=1 for STOR; operand/alu controls held from EXECUTE; on mem_ready: LOAD asserts reg_write=1, data_sel=DATA_WORD; both assert pc_write=1 (PC_INC), retire=1 -> FETCH.
REQ-021 WRITEBACK: reg_write=1, pc_write=1, retire=1 -> FETCH; data_sel=DATA_ALU with pc_sel=PC_INC, except JAL: data_sel=DATA_PC, pc_sel=PC_ADD.
REQ-022 Wait counter (8 bit) SHALL clear on entry to FETCH/MEMORY and on mem_ready, and increment each cycle mem_req=1 and mem_ready=0; reaching MEM_TIMEOUT -> TRAP, trap_cause=2, mem_req dropped the same edge.
REQ-023 mem_ready arriving in the same cycle the counter would reach MEM_TIMEOUT SHALL win (the transfer completes, no trap).
REQ-024 TRAP is absorbing: trap=1, all strobes 0, trap_cause held until reset.
REQ-025 Minimum latency with zero-wait memory: RR/ADDI/LUI/JAL/LOAD/STOR 4 cycles, BEQ 3 cycles, from FETCH entry to retire.

Reset
REQ-026 Asserting reset_n=0 at any time, including mid-transfer, SHALL immediately force state FETCH, IR=0, counter=0, trap=0, trap_cause=0 and all outputs to their REQ-015 idle values with mem_req=0.
REQ-027 The first cycle after reset_n deasserts SHALL present FETCH outputs (mem_req=1).

Structure
REQ-028 isa_t, alu_func_t, data_s_t, pc_s_t and operand_s_t come from the shared constants package; the new FSM state enum and trap_cause encoding SHALL be added to that package.
REQ-029 The instruction decoder (IR -> operand_sel, alu_func, legal) SHALL be a combinational sub-module named isa_decode; the FSM, IR and counter stay in the top module.

Verification
REQ-030 ADD (instr=16'h0000), mem_ready tied 1 -> ir_load in cycle 1, reg_write and retire in cycle 4, alu_func=ALU_ADD in EXECUTE.
REQ-031 BEQ with alu_flag=1 -> pc_write with pc_sel=PC_ADD in cycle 3, no reg_write; with alu_flag=0 -> pc_sel=PC_INC.
REQ-032 STOR with mem_ready delayed 3 cycles in MEMORY -> mem_req and mem_we held 3 cycles, then retire; no reg_write.
REQ-033 MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> trap=1, trap_cause=2 after 4 wait cycles; mem_ready on the 4th cycle instead -> no trap.
REQ-034 Undefined RR funct 3'b010 -> TRAP from DECODE, trap_cause=1, no strobes afterward.
REQ-035 reset_n pulsed low during MEMORY of a LOAD -> mem_req falls asynchronously, no reg_write, fetch restarts after release.
